// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU clock controller.
//   - mode encodings driven on clk_ctrl.i_mode
//   - FSM state encoding
//   - default parameter values used by clk_ctrl and its bench
package clk_ctrl_pkg;

    localparam int DEF_DIV_WIDTH = 32;
    localparam int DEF_STEP_SYNC = 2;
    localparam int DEF_MIN_DIV   = 2;

    // Mode encodings; 2'b11 is reserved and behaves like HALT.
    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_HALT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOW  = 2'b01,
        HIGH = 2'b10
    } state_e;

endpackage

// File: rtl/clk_ctrl_step_sync.sv
// Step-button synchroniser and rising-edge detector.
// Ports:
//   clk        board clock
//   rst        synchronous active-high reset, clears every flop
//   async_in   asynchronous step request
//   edge_pulse one-cycle pulse per synchronised rising edge
// edge_pulse is the AND of two flop outputs, so it is glitch-free and
// adds no extra cycle of latency to the step path.
module step_sync #(
    parameter int SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_DEPTH-1:0] sync_r;
    logic                  prev_r;

    // Synchroniser chain plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], async_in};
            prev_r <= sync_r[SYNC_DEPTH-1];
        end
    end

    assign edge_pulse = sync_r[SYNC_DEPTH-1] & ~prev_r;

endmodule

// File: rtl/clk_ctrl.sv
// CPU clock controller: divides the board clock into o_clk with a
// one-cycle o_tick at the start of each high phase. RUN free-runs,
// HALT stops at the next period end, STEP runs one period per button edge.
// Ports:
//   i_clk      board clock
//   i_rst      synchronous active-high reset
//   i_divider  requested period in i_clk cycles (clamped up to MIN_DIV)
//   i_mode     00 RUN, 01 HALT, 10 STEP, 11 treated as HALT
//   i_step     asynchronous step request, rising edge = one period
//   o_clk      divided clock (registered)
//   o_tick     pulse in first cycle of each o_clk high phase (registered)
//   o_running  high while a period is in progress (registered)
module clk_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int STEP_SYNC = DEF_STEP_SYNC,
    parameter int MIN_DIV   = DEF_MIN_DIV
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DIV_WIDTH-1:0] i_divider,
    input  logic [1:0]           i_mode,
    input  logic                 i_step,
    output logic                 o_clk,
    output logic                 o_tick,
    output logic                 o_running
);

    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] ZERO_W    = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] ONE_W     = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [DIV_WIDTH-1:0] clamp_period(input logic [DIV_WIDTH-1:0] p);
        return (p < MIN_DIV_W) ? MIN_DIV_W : p;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] low_len(input logic [DIV_WIDTH-1:0] p);
        return clamp_period(p) >> 1;
    endfunction

    // Odd periods give the spare cycle to the high phase.
    function automatic logic [DIV_WIDTH-1:0] high_len(input logic [DIV_WIDTH-1:0] p);
        logic [DIV_WIDTH-1:0] pc;
        pc = clamp_period(p);
        return pc - (pc >> 1);
    endfunction

    state_e               state_r, state_s;
    logic [DIV_WIDTH-1:0] cnt_r, cnt_s;
    logic [DIV_WIDTH-1:0] period_r, period_s;
    logic                 clk_r, clk_s;
    logic                 tick_r, tick_s;
    logic                 running_r, running_s;
    logic                 pending_r, pending_s;
    logic                 consume_s;
    logic                 step_edge_s;

    step_sync #(
        .SYNC_DEPTH (STEP_SYNC)
    ) u_step_sync (
        .clk        (i_clk),
        .rst        (i_rst),
        .async_in   (i_step),
        .edge_pulse (step_edge_s)
    );

    // Next-state, counter, latched period and output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        period_s  = period_r;
        clk_s     = 1'b0;
        tick_s    = 1'b0;
        consume_s = 1'b0;
        case (state_r)
            IDLE: begin
                if ((i_mode == MODE_RUN) || ((i_mode == MODE_STEP) && pending_r)) begin
                    state_s   = LOW;
                    period_s  = i_divider;
                    cnt_s     = low_len(i_divider) - ONE_W;
                    consume_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            LOW: begin
                if (cnt_r == ZERO_W) begin
                    state_s = HIGH;
                    cnt_s   = high_len(period_r) - ONE_W;
                    clk_s   = 1'b1;
                    tick_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r - ONE_W;
                end
            end
            HIGH: begin
                if (cnt_r == ZERO_W) begin
                    if (i_mode == MODE_RUN) begin
                        state_s  = LOW;
                        period_s = i_divider;
                        cnt_s    = low_len(i_divider) - ONE_W;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r - ONE_W;
                    clk_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = ZERO_W;
            end
        endcase

        // A fresh edge overrides consumption so it is not lost; leaving
        // STEP mode discards any held step.
        if (i_mode != MODE_STEP) begin
            pending_s = 1'b0;
        end else if (step_edge_s) begin
            pending_s = 1'b1;
        end else if (consume_s) begin
            pending_s = 1'b0;
        end else begin
            pending_s = pending_r;
        end

        running_s = (state_s != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            cnt_r     <= ZERO_W;
            period_r  <= MIN_DIV_W;
            clk_r     <= 1'b0;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            period_r  <= period_s;
            clk_r     <= clk_s;
            tick_r    <= tick_s;
            running_r <= running_s;
            pending_r <= pending_s;
        end
    end

    assign o_clk     = clk_r;
    assign o_tick    = tick_r;
    assign o_running = running_r;

endmodule

// File: tb/tb_clk_ctrl.sv
// Directed bench for clk_ctrl: each vector lists, left to right in time,
// the i_step value driven before an edge and the o_clk / o_tick /
// o_running values expected just after that edge.
module tb_clk_ctrl;
    import clk_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] divider;
    logic [1:0]  mode;
    logic        step;
    logic        dclk;
    logic        tick;
    logic        running;

    int n_checks;
    int n_fail;

    clk_ctrl #(
        .DIV_WIDTH (32),
        .STEP_SYNC (2),
        .MIN_DIV   (2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_divider (divider),
        .i_mode    (mode),
        .i_step    (step),
        .o_clk     (dclk),
        .o_tick    (tick),
        .o_running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs n cycles; bit (n-1-i) of each vector belongs to cycle i.
    task automatic run_vec(input string tag, input int n, input logic [31:0] step_v,
                           input logic [31:0] exp_clk, input logic [31:0] exp_tick,
                           input logic [31:0] exp_run);
        for (int i = 0; i < n; i++) begin
            step = step_v[n-1-i];
            @(posedge clk);
            #1;
            check_eq($sformatf("%s clk c%0d", tag, i), {31'd0, dclk}, {31'd0, exp_clk[n-1-i]});
            check_eq($sformatf("%s tick c%0d", tag, i), {31'd0, tick}, {31'd0, exp_tick[n-1-i]});
            check_eq($sformatf("%s run c%0d", tag, i), {31'd0, running}, {31'd0, exp_run[n-1-i]});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        divider  = 32'd4;
        mode     = MODE_HALT;
        step     = 1'b0;

        // Reset state.
        run_vec("reset", 3, 32'b0, 32'b000, 32'b000, 32'b000);
        rst  = 1'b0;
        mode = MODE_RUN;

        // P=4: tick two cycles after LOW entry, 0011 repeating.
        run_vec("p4", 8, 32'b0, 32'b00110011, 32'b00100010, 32'b11111111);

        // P=5: two low, three high.
        divider = 32'd5;
        run_vec("p5", 10, 32'b0, 32'b0011100111, 32'b0010000100, 32'b1111111111);

        // P=0 and P=1 clamp to a 1-low/1-high period.
        divider = 32'd0;
        run_vec("p0", 6, 32'b0, 32'b010101, 32'b010101, 32'b111111);
        divider = 32'd1;
        run_vec("p1", 6, 32'b0, 32'b010101, 32'b010101, 32'b111111);

        // P=4, change to 8 during high: current period unchanged.
        divider = 32'd4;
        run_vec("p4b", 3, 32'b0, 32'b001, 32'b001, 32'b111);
        divider = 32'd8;
        run_vec("p8", 9, 32'b0, 32'b100001111, 32'b000001000, 32'b111111111);

        // P=6, HALT one cycle into LOW: period finishes then IDLE.
        divider = 32'd6;
        run_vec("p6a", 1, 32'b0, 32'b0, 32'b0, 32'b1);
        mode = MODE_HALT;
        run_vec("halt", 8, 32'b0, 32'b00111000, 32'b00100000, 32'b11111000);

        // STEP: single pulse gives one period.
        divider = 32'd4;
        mode    = MODE_STEP;
        run_vec("step1", 13, 32'b1000000000000, 32'b0000011000000,
                32'b0000010000000, 32'b0001111000000);

        // Two pulses one cycle apart: second is held and runs afterwards.
        run_vec("step2", 14, 32'b10100000000000, 32'b00000110001100,
                32'b00000100001000, 32'b00011110111100);

        // Pulse in HALT is ignored, and not remembered on entering STEP.
        mode = MODE_HALT;
        run_vec("stephalt", 8, 32'b10000000, 32'b0, 32'b0, 32'b0);
        mode = MODE_STEP;
        run_vec("stepafter", 4, 32'b0, 32'b0, 32'b0, 32'b0);

        // Reset during HIGH of a P=8 period, then a clean restart.
        mode    = MODE_RUN;
        divider = 32'd8;
        run_vec("p8r", 6, 32'b0, 32'b000011, 32'b000010, 32'b111111);
        rst = 1'b1;
        run_vec("midrst", 1, 32'b0, 32'b0, 32'b0, 32'b0);
        rst = 1'b0;
        run_vec("restart", 9, 32'b0, 32'b000011110, 32'b000010000, 32'b111111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
